conv3d_feed_master: RTL and testbench

CONV3D_FEED_MASTER -- requirements
Module: conv3d_feed_master

---
 rtl/conv3d_pkg.sv | 28 ++
 rtl/bus_wait_timer.sv | 31 +++
 rtl/conv3d_feed_master.sv | 199 +++++++++++++++++++
 tb/tb_conv3d_feed_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3d_pkg.sv
// Shared constants for the conv3d feed master: accelerator register map,
// default job sizes and the controller state encoding.
package conv3d_pkg;

  localparam int CONV_N_WEIGHT = 25;
  localparam int CONV_N_IMG    = 144;

  localparam logic [31:0] DEV_ADDR_WEIGHT = 32'hC440_0000;
  localparam logic [31:0] DEV_ADDR_IMAGE  = 32'hC440_0004;
  localparam logic [31:0] DEV_ADDR_INDEX  = 32'hC440_0008;
  localparam logic [31:0] DEV_ADDR_RESULT = 32'hC440_000C;

  typedef enum logic [2:0] {
    IDLE,
    MRD_W,
    DWR_W,
    MRD_I,
    DWR_I,
    DWR_IDX,
    DRD_RES,
    DONE
  } state_t;

  function automatic logic is_dev_state(state_t s);
    return (s == DWR_W) || (s == DWR_I) || (s == DWR_IDX) || (s == DRD_RES);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive cycles a device request waits for ready and flags
// expiry on the TIMEOUT-th waiting cycle so the master can abandon it.
module bus_wait_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting   = en_i && !ready_i;
  assign expired_o = waiting && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (waiting) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv3d_feed_master.sv
// Streams kernel weights and image words from memory into the conv
// accelerator, writes the window index and reads back the result.
module conv3d_feed_master
  import conv3d_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int N_WEIGHT = CONV_N_WEIGHT,
  parameter int N_IMG    = CONV_N_IMG,
  parameter int TIMEOUT  = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            reload_i,
  input  logic [XLEN-1:0] w_base_i,
  input  logic [XLEN-1:0] img_base_i,
  input  logic [XLEN-1:0] index_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            en_o,
  output logic            we_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] data_o,
  input  logic            ready_i,
  input  logic [XLEN-1:0] data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [XLEN-1:0] result_o
);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] w_base_q, w_base_d, img_base_q, img_base_d;
  logic [XLEN-1:0] index_q, index_d, word_q, word_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            en_q, en_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
  logic            done_q, done_d, error_q, error_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            tmo;

  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_q),
    .ready_i  (ready_i),
    .expired_o(tmo)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_base_d   = w_base_q;
    img_base_d = img_base_q;
    index_d    = index_q;
    word_d     = word_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    en_d       = en_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    error_d    = error_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          w_base_d   = w_base_i;
          img_base_d = img_base_i;
          index_d    = index_i;
          error_d    = 1'b0;
          cnt_d      = '0;
          if (reload_i) begin
            state_d    = MRD_W;
            mem_req_d  = 1'b1;
            mem_addr_d = w_base_i;
          end else begin
            state_d = DWR_IDX;
          end
        end
      end
      MRD_W, MRD_I: begin
        if (mem_req_q && mem_ack_i) begin
          mem_req_d = 1'b0;
          word_d    = mem_rdata_i;
          state_d   = (state_q == MRD_W) ? DWR_W : DWR_I;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        // Every device state enters with en low, giving the mandatory idle
        // cycle between back-to-back device transactions.
        if (!en_q) begin
          en_d = 1'b1;
          we_d = (state_q != DRD_RES);
          unique case (state_q)
            DWR_W:   begin addr_d = XLEN'(DEV_ADDR_WEIGHT); data_d = word_q;  end
            DWR_I:   begin addr_d = XLEN'(DEV_ADDR_IMAGE);  data_d = word_q;  end
            DWR_IDX: begin addr_d = XLEN'(DEV_ADDR_INDEX);  data_d = index_q; end
            default: begin addr_d = XLEN'(DEV_ADDR_RESULT); data_d = '0;      end
          endcase
        end else if (tmo) begin
          en_d    = 1'b0;
          error_d = 1'b1;
          state_d = IDLE;
        end else if (ready_i) begin
          en_d = 1'b0;
          unique case (state_q)
            DWR_W: begin
              mem_req_d = 1'b1;
              if (cnt_inc == 8'(N_WEIGHT)) begin
                cnt_d      = '0;
                state_d    = MRD_I;
                mem_addr_d = img_base_q;
              end else begin
                cnt_d      = cnt_inc;
                state_d    = MRD_W;
                mem_addr_d = w_base_q + XLEN'({cnt_inc, 2'b00});
              end
            end
            DWR_I: begin
              if (cnt_inc == 8'(N_IMG)) begin
                cnt_d   = '0;
                state_d = DWR_IDX;
              end else begin
                cnt_d      = cnt_inc;
                state_d    = MRD_I;
                mem_req_d  = 1'b1;
                mem_addr_d = img_base_q + XLEN'({cnt_inc, 2'b00});
              end
            end
            DWR_IDX: state_d = DRD_RES;
            default: begin
              result_d = data_i;
              done_d   = 1'b1;
              state_d  = DONE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_base_q   <= '0;
      img_base_q <= '0;
      index_q    <= '0;
      word_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_base_q   <= w_base_d;
      img_base_q <= img_base_d;
      index_q    <= index_d;
      word_q     <= word_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      result_q   <= result_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign en_o       = en_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_conv3d_feed_master.sv
// Randomized bench: memory/device responders log every device transaction,
// which is compared against the transaction list a job should produce.
module tb_conv3d_feed_master;
  import conv3d_pkg::*;

  localparam int NW = 25;
  localparam int NI = 144;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_i, reload_i, mem_ack_i, ready_i;
  logic [31:0] w_base_i, img_base_i, index_i, mem_rdata_i, data_i;
  logic        mem_req_o, en_o, we_o, busy_o, done_o, error_o;
  logic [31:0] mem_addr_o, addr_o, data_o, result_o;

  logic        start_t, ready_t;
  logic [31:0] index_t;
  logic        mem_req_t, en_t, we_t, busy_t, done_t, error_t;
  logic [31:0] mem_addr_t, addr_t, data_t, result_t;

  conv3d_feed_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .reload_i(reload_i),
    .w_base_i(w_base_i), .img_base_i(img_base_i), .index_i(index_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .en_o(en_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .ready_i(ready_i), .data_i(data_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .result_o(result_o)
  );

  conv3d_feed_master #(.TIMEOUT(16)) dut_to (
    .clk_i(clk), .rst_i(rst), .start_i(start_t), .reload_i(1'b0),
    .w_base_i(32'h0), .img_base_i(32'h0), .index_i(index_t),
    .mem_req_o(mem_req_t), .mem_addr_o(mem_addr_t), .mem_ack_i(1'b0),
    .mem_rdata_i(32'h0), .en_o(en_t), .we_o(we_t), .addr_o(addr_t),
    .data_o(data_t), .ready_i(ready_t), .data_i(32'h0), .busy_o(busy_t),
    .done_o(done_t), .error_o(error_t), .result_o(result_t)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment shared with the responders.
  int          max_rdy = 0, max_ack = 0;
  bit          spur = 0;
  logic [31:0] wb = 0, ib = 0, res_val = 0;
  txn_t        dev_log[$];
  int          mem_cnt = 0, done_cnt = 0;

  // Memory image: weight i is i+1, image word i is 100+i, else a tagged hash.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a - wb < 32'(4 * NW)) return ((a - wb) >> 2) + 32'd1;
    if (a - ib < 32'(4 * NI)) return ((a - ib) >> 2) + 32'd100;
    return 32'hDEAD_0000 ^ a;
  endfunction

  bit          d_seen = 0, m_seen = 0;
  int          d_dly = 0, m_dly = 0;
  logic [31:0] s_addr, s_data, s_maddr;
  logic        s_we;

  initial begin
    txn_t t;
    ready_i = 1'b0;
    data_i  = '0;
    forever begin
      @(negedge clk);
      check("excl", 32'(en_o & mem_req_o), 32'd0);
      if (!en_o) d_seen = 0;
      if (ready_i) begin
        ready_i = 1'b0;
        d_dly   = $urandom_range(0, max_rdy);
      end else if (en_o) begin
        if (!d_seen) begin
          d_seen = 1; s_addr = addr_o; s_data = data_o; s_we = we_o;
        end else begin
          check("dev_addr_hold", addr_o, s_addr);
          check("dev_data_hold", data_o, s_data);
          check("dev_we_hold", 32'(we_o), 32'(s_we));
        end
        if (d_dly == 0) begin
          ready_i = 1'b1;
          data_i  = we_o ? $urandom : res_val;
          t.we = we_o; t.addr = addr_o; t.data = data_o;
          dev_log.push_back(t);
          d_seen = 0;
        end else d_dly--;
      end else if (spur && $urandom_range(0, 7) == 0) begin
        ready_i = 1'b1;
        data_i  = $urandom;
      end
    end
  end

  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!mem_req_o) m_seen = 0;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        m_dly     = $urandom_range(0, max_ack);
      end else if (mem_req_o) begin
        if (!m_seen) begin
          m_seen = 1; s_maddr = mem_addr_o;
        end else check("mem_addr_hold", mem_addr_o, s_maddr);
        if (m_dly == 0) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_val(mem_addr_o);
          mem_cnt++;
          m_seen = 0;
        end else m_dly--;
      end else if (spur && $urandom_range(0, 7) == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o) done_cnt++;
  end

  task automatic start_job(input bit reload, input logic [31:0] idx);
    wb = $urandom & 32'hFFFF_FFFC;
    ib = wb + 32'h0000_1000;
    dev_log.delete();
    mem_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; reload_i = reload; index_i = idx;
    w_base_i = wb; img_base_i = ib;
    @(negedge clk);
    // Scramble inputs so only the latched copies can produce correct traffic.
    start_i = 1'b0; reload_i = $urandom; index_i = $urandom;
    w_base_i = $urandom; img_base_i = $urandom;
  endtask

  task automatic do_job(input string tag, input bit reload, input logic [31:0] idx,
                        input logic [31:0] res, input int n_busy_starts);
    txn_t exp[$];
    txn_t t;
    bit   fin = 0;
    int   left = n_busy_starts;
    res_val = res;
    if (reload) begin
      for (int i = 0; i < NW; i++) begin
        t.we = 1; t.addr = DEV_ADDR_WEIGHT; t.data = 32'(i + 1); exp.push_back(t);
      end
      for (int i = 0; i < NI; i++) begin
        t.we = 1; t.addr = DEV_ADDR_IMAGE; t.data = 32'(100 + i); exp.push_back(t);
      end
    end
    t.we = 1; t.addr = DEV_ADDR_INDEX;  t.data = idx; exp.push_back(t);
    t.we = 0; t.addr = DEV_ADDR_RESULT; t.data = '0;  exp.push_back(t);

    start_job(reload, idx);
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      if (done_o) fin = 1;
      if (left > 0 && busy_o && !done_o && $urandom_range(0, 3) == 0) begin
        start_i = 1'b1; reload_i = $urandom; index_i = $urandom;
        left--;
      end else start_i = 1'b0;
    end
    start_i = 1'b0;
    check({tag, "_finished"}, 32'(fin), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_error"}, 32'(error_o), 32'd0);
    check({tag, "_result"}, result_o, res);
    check({tag, "_mem_reads"}, 32'(mem_cnt), reload ? 32'(NW + NI) : 32'd0);
    check({tag, "_n_txn"}, 32'(dev_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dev_log.size(); i++) begin
      check({tag, "_we"}, 32'(dev_log[i].we), 32'(exp[i].we));
      check({tag, "_addr"}, dev_log[i].addr, exp[i].addr);
      if (exp[i].we) check({tag, "_data"}, dev_log[i].data, exp[i].data);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_error"}, 32'(error_o), 32'd0);
    check({tag, "_en"}, 32'(en_o), 32'd0);
    check({tag, "_we"}, 32'(we_o), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_addr"}, addr_o, 32'd0);
    check({tag, "_data"}, data_o, 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "_result"}, result_o, 32'd0);
  endtask

  initial begin
    bit fin;
    int rd, wr, dn;
    start_i = 0; reload_i = 0; w_base_i = 0; img_base_i = 0; index_i = 0;
    start_t = 0; ready_t = 0; index_t = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    do_job("reload", 1'b1, $urandom, $urandom, 0);
    do_job("compute", 1'b0, 32'd13, 32'h42C8_0000, 0);

    max_rdy = 20; max_ack = 8; spur = 1;
    do_job("bp_reload", 1'b1, $urandom, $urandom, 0);
    do_job("bp_compute", 1'b0, $urandom, $urandom, 0);
    do_job("busy_start_reload", 1'b1, $urandom, $urandom, 6);
    do_job("busy_start_compute", 1'b0, $urandom, $urandom, 3);

    // Reset in the middle of the image stream.
    start_job(1'b1, $urandom);
    fin = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      if (dev_log.size() >= NW + 70) fin = 1;
    end
    check("mid_reset_reached", 32'(fin), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_job("after_reset", 1'b1, $urandom, $urandom, 0);

    // Device never answers the result read.
    @(negedge clk);
    start_t = 1'b1; index_t = $urandom;
    @(negedge clk);
    start_t = 1'b0;
    rd = 0; wr = 0; dn = 0; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (done_t) dn++;
      if (ready_t) ready_t = 1'b0;
      else if (en_t && we_t) begin ready_t = 1'b1; wr++; end
      if (en_t && !we_t) rd++;
      if (!busy_t) fin = 1;
    end
    check("tmo_ended", 32'(fin), 32'd1);
    check("tmo_wait_cycles", 32'(rd), 32'd16);
    check("tmo_writes", 32'(wr), 32'd1);
    check("tmo_no_done", 32'(dn), 32'd0);
    check("tmo_error", 32'(error_t), 32'd1);
    check("tmo_en", 32'(en_t), 32'd0);
    repeat (3) @(negedge clk);
    check("tmo_error_sticky", 32'(error_t), 32'd1);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("tmo_error_cleared", 32'(error_t), 32'd0);
    check("tmo_busy_restart", 32'(busy_t), 32'd1);

    for (int j = 0; j < 3; j++) begin
      max_rdy = $urandom_range(0, 20);
      max_ack = $urandom_range(0, 10);
      do_job("rand_job", 1'($urandom), $urandom, $urandom, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
